// File: rtl/hazard_controller.sv
// hazard_controller: decode-side stall/bubble/flush/freeze sequencing with in-flight slot shadowing and stall counter
module hazard_controller #(
  parameter bit FORWARD_EN = 1'b0,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic             src2_used,
  input  logic [4:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_en,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             ifid_freeze,
  output logic             id_bubble,
  output logic             pipe_freeze,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);
  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       wb;
    logic       mr;
    logic       me;
  } slot_t;
  typedef enum logic [1:0] {RUN = 2'b00, DATA_STALL = 2'b01, MEM_WAIT = 2'b10} state_t;
  slot_t exe, mem, wb;
  state_t st;
  logic h_exe, h_mem, h_wb, data_hazard, mem_stall, unused_wb;
  function automatic logic hit(input logic [4:0] s, input slot_t x);
    return x.v && x.wb && s == x.d && s != 5'd0;
  endfunction
  always_comb begin
    h_exe = hit(src1, exe) || (src2_used && hit(src2, exe));
    h_mem = hit(src1, mem) || (src2_used && hit(src2, mem));
    h_wb = hit(src1, wb) || (src2_used && hit(src2, wb));
    data_hazard = FORWARD_EN ? h_exe && exe.mr : h_exe || h_mem || (!WB_BYPASS && h_wb);
    mem_stall = mem.v && mem.me && !mem_ready;
    st = mem_stall ? MEM_WAIT : data_hazard ? DATA_STALL : RUN;
    pc_freeze = st != RUN;
    ifid_freeze = st != RUN;
    id_bubble = st == DATA_STALL;
    pipe_freeze = st == MEM_WAIT;
    if_flush = st == RUN && br_taken;
  end
  assign state = st;
  assign unused_wb = wb.mr ^ wb.me;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe <= '0;
      mem <= '0;
      wb <= '0;
      stall_cnt <= '0;
    end else begin
      if (st != MEM_WAIT) begin
        exe <= st == RUN ? slot_t'{1'b1, id_dest, id_wb_en && !br_taken, id_mem_r_en, id_mem_en} : '0;
        mem <= exe;
        wb <= mem;
      end
      if (st != RUN && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller sitting beside the decode stage.
- Shadows the destination/write-enable of every in-flight instruction (EXE, MEM, WB slots) and compares it against the decoding instruction's source registers.
- Drives PC/IF-ID freeze, ID/EXE bubble insertion, IF flush on taken branches, and a global freeze while data memory is not ready.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- FORWARD_EN, 0: 1 = forwarding unit present; only a load in EXE causes a data hazard.
- WB_BYPASS, 1: 1 = register file is write-through; a match in the WB slot is not a hazard.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- src1  in  5  ID source register 1 (Instruction[20:16])
- src2  in  5  ID source register 2 (Instruction[15:11])
- src2_used  in  1  src2 is read (register-type or store)
- id_dest  in  5  ID destination register
- id_wb_en  in  1  ID instruction writes back
- id_mem_r_en  in  1  ID instruction is a load
- id_mem_en  in  1  ID instruction accesses memory (load or store)
- br_taken  in  1  ID instruction is a taken branch
- mem_ready  in  1  data memory can complete the access in MEM this cycle
- pc_freeze  out  1  hold PC
- ifid_freeze  out  1  hold IF/ID register
- id_bubble  out  1  load NOP (all enables 0) into ID/EXE
- pipe_freeze  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers
- if_flush  out  1  clear IF/ID register
- stall_cnt  out  CNT_W  saturating count of non-RUN cycles
- state  out  2  00 RUN, 01 DATA_STALL, 10 MEM_WAIT

Behaviour:
- Slots: EXE, MEM and WB each hold {valid, dest[4:0], wb_en, mem_r_en, mem_en}. Reset clears all slots to 0.
- Hazard match: src == slot.dest, slot.valid and slot.wb_en, and src != 0. src2 is checked only when src2_used=1.
- data_hazard when FORWARD_EN=0:
  - any match in EXE or MEM; or
  - a match in WB when WB_BYPASS=0.
- data_hazard when FORWARD_EN=1: a match in EXE with EXE.mem_r_en=1.
- mem_stall = MEM.valid & MEM.mem_en & !mem_ready. It has priority over data_hazard.
- State for the current cycle (combinational):
  - MEM_WAIT if mem_stall;
  - else DATA_STALL if data_hazard;
  - else RUN.
- RUN:
  - All freezes low.
  - Slots shift: EXE <= ID info with valid=1; MEM <= EXE; WB <= MEM.
  - if_flush = br_taken. A branch never sets wb_en in its slot.
- DATA_STALL:
  - pc_freeze=1, ifid_freeze=1, id_bubble=1, if_flush=0 (a branch stalled on an operand does not flush until it issues).
  - Slots shift with EXE <= bubble (valid=0); MEM <= EXE; WB <= MEM.
- MEM_WAIT:
  - pc_freeze=1, ifid_freeze=1, pipe_freeze=1, id_bubble=0, if_flush=0.
  - All slots hold.
  - Leaves on the first cycle mem_ready=1; in that cycle data_hazard/RUN rules apply.
- Output timing: all outputs are combinational from the current slots and inputs; slots and stall_cnt are registered.
- stall_cnt:
  - Increments on each clock edge where state != RUN.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Reset: asserting rst=0 at any time clears slots, stall_cnt=0 and state=RUN immediately. With empty slots all outputs evaluate to 0, except if_flush, which follows br_taken.
- Simultaneous events: mem_stall with data_hazard -> MEM_WAIT only. data_hazard with br_taken -> DATA_STALL, no flush.
- Register 0 never causes a hazard, even when written.

Test Plan:
- Reset and empty pipe: rst low mid-stall -> all outputs 0, stall_cnt=0. Then issue ADD r3 (no sources in flight) -> state RUN, no freeze.
- Back-to-back RAW, FORWARD_EN=0, WB_BYPASS=1: write r5, then an instruction reading src1=5 -> DATA_STALL for exactly 2 cycles, id_bubble=1 both cycles, stall_cnt=2, then RUN.
- Load-use, FORWARD_EN=1: load to r7, then reader of src2=7 with src2_used=1 -> 1 stall cycle. The same reader with src2_used=0 -> no stall. A writer to r0 then a reader of r0 -> no stall.
- Memory wait: load in MEM with mem_ready=0 for 3 cycles -> MEM_WAIT 3 cycles, pipe_freeze=1, slots unchanged. On the 4th cycle mem_ready=1 -> RUN; stall_cnt=3.
- Branch: br_taken=1 with no hazard -> if_flush=1 for one cycle. Branch whose src1 matches EXE.dest -> no flush during DATA_STALL; if_flush=1 in the issuing cycle.
- Saturation, CNT_W=4: hold mem_ready=0 for 20 cycles -> stall_cnt stops at 15.
